// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID->EX issue/hazard controller.
// Used by hazard_ctrl and reg_scoreboard.
package hazard_pkg;

    localparam int NREG     = 32;
    localparam int RS_W     = 5;
    localparam int PC_W     = 32;
    localparam int SB_CNT_W = 2;
    localparam int PERF_W   = 32;

    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Register index 0 is hardwired zero and never tracked.
    function automatic logic is_tracked(input logic [RS_W-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters; answers "is rs busy" from the registered counts.
// x0 is never tracked, so its busy bit is constant zero.
module reg_scoreboard
    import hazard_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_en,
    input  logic [RS_W-1:0] inc_idx,
    input  logic            dec_en,
    input  logic [RS_W-1:0] dec_idx,
    input  logic [RS_W-1:0] rs1,
    input  logic [RS_W-1:0] rs2,
    output logic            busy1,
    output logic            busy2,
    output logic            empty
);

    logic [NREG-1:0] busy_vec;

    assign busy_vec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_cnt
            logic [SB_CNT_W-1:0] cnt_reg;
            logic [SB_CNT_W-1:0] cnt_next;
            logic                inc_hit;
            logic                dec_hit;

            assign inc_hit = inc_en && (inc_idx == RS_W'(gi));
            assign dec_hit = dec_en && (dec_idx == RS_W'(gi));

            // A simultaneous issue and retire of the same register cancel out.
            always_comb begin
                cnt_next = cnt_reg;
                if (inc_hit && !dec_hit) begin
                    cnt_next = cnt_reg + 1'b1;
                end else if (dec_hit && !inc_hit) begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    assert (!(inc_hit && !dec_hit && cnt_reg == SB_CNT_MAX))
                        else $error("scoreboard overflow on x%0d", gi);
                    assert (!(dec_hit && !inc_hit && cnt_reg == '0))
                        else $error("scoreboard underflow on x%0d", gi);
                end
            end

            assign busy_vec[gi] = |cnt_reg;
        end
    endgenerate

    assign busy1 = busy_vec[rs1];
    assign busy2 = busy_vec[rs2];
    assign empty = ~|busy_vec;

endmodule

// File: rtl/hazard_ctrl.sv
// ID->EX issue controller: RAW stall via write scoreboard, fence drain, redirect flush.
// Define YSYX_23060251_HAZARD_PERF_EN to add the perf counter ports.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              d_valid_i,
    input  logic [RS_W-1:0]   d_rs1_i,
    input  logic [RS_W-1:0]   d_rs2_i,
    input  logic              d_use_rs1_i,
    input  logic              d_use_rs2_i,
    input  logic [RS_W-1:0]   d_rd_i,
    input  logic              d_wenReg_i,
    input  logic              d_fence_i,
    output logic              d_issue_ok_o,
    input  logic              e_fire_i,
    input  logic              w_valid_i,
    input  logic [RS_W-1:0]   w_rd_i,
    input  logic              w_wenReg_i,
    input  logic              e_redirect_i,
    input  logic [PC_W-1:0]   e_redirect_pc_i,
    output logic              flush_o,
    output logic              f_redirect_o,
    output logic [PC_W-1:0]   f_redirect_pc_o
`ifdef YSYX_23060251_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_raw_cnt_o,
    output logic [PERF_W-1:0] perf_flush_cnt_o,
    output logic [PERF_W-1:0] perf_drain_cnt_o
`endif
);

    state_t          state_reg;
    state_t          state_next;
    logic [PC_W-1:0] pc_reg;
    logic            sb_inc;
    logic            sb_dec;
    logic            busy1;
    logic            busy2;
    logic            sb_empty;
    logic            raw;
    logic            fence_wait;
    logic            in_run;

    assign sb_inc = e_fire_i && d_wenReg_i && is_tracked(d_rd_i);
    assign sb_dec = w_valid_i && w_wenReg_i && is_tracked(w_rd_i);

    reg_scoreboard u_sb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_en  (sb_inc),
        .inc_idx (d_rd_i),
        .dec_en  (sb_dec),
        .dec_idx (w_rd_i),
        .rs1     (d_rs1_i),
        .rs2     (d_rs2_i),
        .busy1   (busy1),
        .busy2   (busy2),
        .empty   (sb_empty)
    );

    assign raw        = (d_use_rs1_i && busy1) || (d_use_rs2_i && busy2);
    assign fence_wait = d_fence_i && !sb_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // A redirect wins in every state, including a back-to-back redirect in FLUSH.
    always_comb begin
        state_next = state_reg;
        if (e_redirect_i) begin
            state_next = ST_FLUSH;
        end else begin
            case (state_reg)
                ST_RUN:   if (d_valid_i && fence_wait) state_next = ST_DRAIN;
                ST_FLUSH: state_next = ST_RUN;
                ST_DRAIN: if (sb_empty) state_next = ST_RUN;
                default:  state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        flush_o      = 1'b0;
        f_redirect_o = 1'b0;
        in_run       = 1'b0;
        case (state_reg)
            ST_RUN:   in_run = 1'b1;
            ST_FLUSH: begin
                flush_o      = 1'b1;
                f_redirect_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign d_issue_ok_o = in_run && !raw && !e_redirect_i && !fence_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_reg <= '0;
        end else if (e_redirect_i) begin
            pc_reg <= e_redirect_pc_i;
        end
    end

    assign f_redirect_pc_o = pc_reg;

`ifdef YSYX_23060251_HAZARD_PERF_EN
    logic [PERF_W-1:0] raw_cnt_reg;
    logic [PERF_W-1:0] flush_cnt_reg;
    logic [PERF_W-1:0] drain_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_cnt_reg   <= '0;
            flush_cnt_reg <= '0;
            drain_cnt_reg <= '0;
        end else begin
            if (d_valid_i && raw)       raw_cnt_reg   <= raw_cnt_reg + 1'b1;
            if (e_redirect_i)           flush_cnt_reg <= flush_cnt_reg + 1'b1;
            if (state_reg == ST_DRAIN)  drain_cnt_reg <= drain_cnt_reg + 1'b1;
        end
    end

    assign perf_raw_cnt_o   = raw_cnt_reg;
    assign perf_flush_cnt_o = flush_cnt_reg;
    assign perf_drain_cnt_o = drain_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a pipeline model of in-flight writes predicts issue/flush/redirect.
// Honours YSYX_23060251_HAZARD_PERF_EN for the perf ports.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              d_valid_i = 0, d_use_rs1_i = 0, d_use_rs2_i = 0, d_wenReg_i = 0, d_fence_i = 0;
    logic [RS_W-1:0]   d_rs1_i = '0, d_rs2_i = '0, d_rd_i = '0, w_rd_i = '0;
    logic              e_fire_i = 0, w_valid_i = 0, w_wenReg_i = 0, e_redirect_i = 0;
    logic [PC_W-1:0]   e_redirect_pc_i = '0;
    logic              d_issue_ok_o, flush_o, f_redirect_o;
    logic [PC_W-1:0]   f_redirect_pc_o;
`ifdef YSYX_23060251_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_raw_cnt_o, perf_flush_cnt_o, perf_drain_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    hazard_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .d_valid_i(d_valid_i), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i),
        .d_use_rs1_i(d_use_rs1_i), .d_use_rs2_i(d_use_rs2_i),
        .d_rd_i(d_rd_i), .d_wenReg_i(d_wenReg_i), .d_fence_i(d_fence_i),
        .d_issue_ok_o(d_issue_ok_o), .e_fire_i(e_fire_i),
        .w_valid_i(w_valid_i), .w_rd_i(w_rd_i), .w_wenReg_i(w_wenReg_i),
        .e_redirect_i(e_redirect_i), .e_redirect_pc_i(e_redirect_pc_i),
        .flush_o(flush_o), .f_redirect_o(f_redirect_o), .f_redirect_pc_o(f_redirect_pc_o)
`ifdef YSYX_23060251_HAZARD_PERF_EN
        , .perf_raw_cnt_o(perf_raw_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o),
        .perf_drain_cnt_o(perf_drain_cnt_o)
`endif
    );

    typedef struct { logic [RS_W-1:0] rd; bit wen; } inst_t;
    typedef struct { bit ok; bit flush; } exp_t;

    localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2;

    inst_t       pend[$];      // instructions between id_ex and retirement, oldest first
    exp_t        exp_q[$];
    logic [31:0] pc_q[$];
    int          mode = M_RUN;
    int          n_cmp = 0, n_bad = 0;
    int          m_raw = 0, m_flush = 0, m_drain = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int writers_of(logic [RS_W-1:0] r);
        int c = 0;
        foreach (pend[i]) if (pend[i].wen && pend[i].rd != 0 && pend[i].rd == r) c++;
        return c;
    endfunction

    function automatic bit nothing_in_flight();
        foreach (pend[i]) if (pend[i].wen && pend[i].rd != 0) return 0;
        return 1;
    endfunction

    // One ID cycle: drive inputs at the falling edge and record what the DUT must show.
    task automatic step(input bit dv, input logic [RS_W-1:0] rs1, input bit u1,
                        input logic [RS_W-1:0] rs2, input bit u2,
                        input logic [RS_W-1:0] rd, input bit wen, input bit fence,
                        input bit want_fire, input bit want_retire,
                        input bit redir, input logic [31:0] rpc);
        bit raw, empty, ok, retire, fire;
        @(negedge clk_i);
        empty  = nothing_in_flight();
        raw    = (u1 && writers_of(rs1) > 0) || (u2 && writers_of(rs2) > 0);
        ok     = (mode == M_RUN) && !raw && !redir && !(fence && !empty);
        retire = want_retire && pend.size() > 0;
        fire   = dv && ok && want_fire && pend.size() < 3;

        d_valid_i = dv; d_rs1_i = rs1; d_use_rs1_i = u1; d_rs2_i = rs2; d_use_rs2_i = u2;
        d_rd_i = rd; d_wenReg_i = wen; d_fence_i = fence; e_fire_i = fire;
        w_valid_i  = retire;
        w_rd_i     = retire ? pend[0].rd  : RS_W'($urandom);
        w_wenReg_i = retire ? pend[0].wen : 1'($urandom);
        e_redirect_i = redir; e_redirect_pc_i = rpc;

        exp_q.push_back('{ok, mode == M_FLUSH});
        if (redir) pc_q.push_back(rpc);

        if (dv && raw) m_raw++;
        if (mode == M_DRAIN) m_drain++;
        if (redir) m_flush++;

        if (redir) mode = M_FLUSH;
        else if (mode == M_FLUSH) mode = M_RUN;
        else if (mode == M_RUN && dv && fence && !empty) mode = M_DRAIN;
        else if (mode == M_DRAIN && empty) mode = M_RUN;

        if (retire) void'(pend.pop_front());
        if (fire) pend.push_back('{rd, wen});
    endtask

    task automatic idle(input int n, input bit retire);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, retire, 0, 0);
    endtask

    task automatic rand_step();
        step($urandom_range(0, 3) != 0,
             RS_W'($urandom_range(0, 7)), 1'($urandom), RS_W'($urandom_range(0, 7)), 1'($urandom),
             RS_W'($urandom_range(0, 7)), $urandom_range(0, 4) != 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 24) == 0, $urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        chk({tag, "_flush"}, flush_o, 0);
        chk({tag, "_redirect"}, f_redirect_o, 0);
        chk({tag, "_pc"}, f_redirect_pc_o, 0);
        chk({tag, "_issue_ok"}, d_issue_ok_o, 1);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk_i);
        rst_i = 1'b1;
        d_valid_i = 0; e_fire_i = 0; w_valid_i = 0; e_redirect_i = 0; d_fence_i = 0;
        d_use_rs1_i = 0; d_use_rs2_i = 0;
        repeat (n) @(negedge clk_i);
        rst_i = 1'b0;
        pend.delete(); exp_q.delete(); pc_q.delete();
        mode = M_RUN; m_raw = 0; m_flush = 0; m_drain = 0;
        check_reset_outputs("reset");
    endtask

    // Per-cycle monitor for the issue gate and flush pulse.
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        #2;
        if (!rst_i && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_ok", d_issue_ok_o, e.ok);
            chk("flush_o", flush_o, e.flush);
            chk("f_redirect_o", f_redirect_o, e.flush);
        end
    end

    // Redirect monitor: every fetch redirect must match the oldest outstanding redirect pc.
    initial forever begin
        @(negedge clk_i);
        #3;
        if (!rst_i && f_redirect_o) begin
            if (pc_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL redirect_pc: got unexpected redirect to %h, required none", f_redirect_pc_o);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = pc_q.pop_front();
                $display("redirect pc=%h expected=%h", f_redirect_pc_o, exp_pc);
                chk("redirect_pc", f_redirect_pc_o, exp_pc);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check_reset_outputs("init");

        // add x5, then a reader of x5 stalls through the WB cycle and issues the cycle after
        step(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0);
        step(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 0, 0);
        step(1, 5, 1, 0, 0, 6, 1, 0, 1, 1, 0, 0);
        step(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 0, 0);
        idle(3, 1);

        // writes to x0 are never tracked
        repeat (3) step(1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
        idle(4, 1);

        // same-cycle issue and retire of x7 keeps it busy
        step(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 1, 1, 0, 0);
        step(1, 7, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        idle(3, 1);

        // three writes to x9 in flight, then three retirements
        repeat (3) step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 9, 1, 2, 1, 0, 1, 0, 0, 0);
        idle(3, 1);
        step(1, 0, 0, 9, 1, 2, 1, 0, 0, 0, 0, 0);

        // redirect: one-cycle flush with the new pc, then back to normal
        idle(4, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 32'h8000_0040);
        idle(2, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 32'h8000_0100);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 32'h8000_0200);
        idle(2, 0);

        // fence drains two writes; a second fence is cut short by a redirect
        step(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h8000_0400);
        idle(4, 1);

        repeat (1500) rand_step();
        apply_reset(2);
        repeat (1500) rand_step();
        idle(8, 1);

        n_cmp++;
        if (pc_q.size() != 0) begin
            n_bad++;
            $display("FAIL redirect_outstanding: got %0d unserved redirects, required 0", pc_q.size());
        end
`ifdef YSYX_23060251_HAZARD_PERF_EN
        chk("perf_raw", perf_raw_cnt_o, m_raw);
        chk("perf_flush", perf_flush_cnt_o, m_flush);
        chk("perf_drain", perf_drain_cnt_o, m_drain);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
